// File: rtl/nlm_linebuf_ctrl.sv
// nlm_linebuf_ctrl: circular line-buffer sequencer for the NLM RAW-denoise stage.
// Writes each incoming row into a rotating SRAM bank. Once NUM_LINES-1 rows are
// stored, it reads the older banks column-aligned with the live pixel.
// Optional build macro NLM_LBUF_ERR_EN adds a sticky err_o protocol flag.
module nlm_linebuf_ctrl #(
  parameter  int ADDR_WIDTH = 8,
  parameter  int NUM_LINES  = 4,
  parameter  int HGT_WIDTH  = 12,
  localparam int BANK_W     = $clog2(NUM_LINES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sof_i,
  input  logic                  pix_valid_i,
  input  logic [ADDR_WIDTH:0]   img_width_i,
  input  logic [HGT_WIDTH-1:0]  img_height_i,
  output logic [NUM_LINES-1:0]  wren_o,
  output logic [ADDR_WIDTH-1:0] wraddr_o,
  output logic                  rden_o,
  output logic [ADDR_WIDTH-1:0] rdaddr_o,
  output logic [BANK_W-1:0]     bank_ptr_o,
  output logic                  win_valid_o,
  output logic [ADDR_WIDTH-1:0] win_col_o,
  output logic [HGT_WIDTH-1:0]  win_row_o,
  output logic                  frame_done_o,
  output logic                  busy_o
`ifdef NLM_LBUF_ERR_EN
  ,
  output logic                  err_o
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_DONE} state_t;

  localparam logic [ADDR_WIDTH:0]  MAX_W     = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]  COL_ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [HGT_WIDTH-1:0] ROW_ONE   = HGT_WIDTH'(1);
  localparam logic [HGT_WIDTH-1:0] FILL_LAST = HGT_WIDTH'(NUM_LINES - 2);
  localparam logic [BANK_W-1:0]    BANK_ONE  = BANK_W'(1);
  localparam logic [BANK_W-1:0]    BANK_LAST = BANK_W'(NUM_LINES - 1);

  state_t                state_q, state_d, eff_state;
  logic [ADDR_WIDTH:0]   col_q, col_d, eff_col;
  logic [HGT_WIDTH-1:0]  row_q, row_d, eff_row;
  logic [BANK_W-1:0]     bank_q, bank_d, eff_bank;
  logic [ADDR_WIDTH:0]   width_q, eff_width;
  logic [HGT_WIDTH-1:0]  height_q, eff_height;
  logic                  sof_ok, accept, eol, last_row;

  // A valid sof_i overrides the registered context in the same cycle so that a
  // coincident pixel is handled as column 0, row 0, bank 0 of the new frame.
  always_comb begin
    sof_ok     = sof_i && (img_width_i != '0) && (img_width_i <= MAX_W) &&
                 (img_height_i != '0);
    eff_state  = sof_ok ? S_FILL       : state_q;
    eff_col    = sof_ok ? '0           : col_q;
    eff_row    = sof_ok ? '0           : row_q;
    eff_bank   = sof_ok ? '0           : bank_q;
    eff_width  = sof_ok ? img_width_i  : width_q;
    eff_height = sof_ok ? img_height_i : height_q;

    accept   = pix_valid_i && ((eff_state == S_FILL) || (eff_state == S_RUN));
    eol      = (eff_col == (eff_width - COL_ONE));
    last_row = (eff_row == (eff_height - ROW_ONE));

    state_d  = eff_state;
    col_d    = eff_col;
    row_d    = eff_row;
    bank_d   = eff_bank;
    wren_o   = '0;
    rden_o   = 1'b0;
    wraddr_o = eff_col[ADDR_WIDTH-1:0];
    rdaddr_o = eff_col[ADDR_WIDTH-1:0];

    if (eff_state == S_DONE) state_d = S_IDLE;

    if (accept) begin
      wren_o[eff_bank] = 1'b1;
      rden_o           = (eff_state == S_RUN);
      if (eol) begin
        col_d  = '0;
        row_d  = eff_row + ROW_ONE;
        bank_d = (eff_bank == BANK_LAST) ? '0 : eff_bank + BANK_ONE;
        if (last_row)
          state_d = S_DONE;
        else if ((eff_state == S_FILL) && (eff_row == FILL_LAST))
          state_d = S_RUN;
      end else begin
        col_d = eff_col + COL_ONE;
      end
    end
  end

  // State, counters and latched frame geometry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      col_q    <= '0;
      row_q    <= '0;
      bank_q   <= '0;
      width_q  <= '0;
      height_q <= '0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      bank_q   <= bank_d;
      width_q  <= eff_width;
      height_q <= eff_height;
    end
  end

  // Window tags registered to line up with SRAM read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_valid_o <= 1'b0;
      win_col_o   <= '0;
      win_row_o   <= '0;
      bank_ptr_o  <= '0;
    end else begin
      win_valid_o <= rden_o;
      win_col_o   <= eff_col[ADDR_WIDTH-1:0];
      win_row_o   <= eff_row;
      bank_ptr_o  <= eff_bank;
    end
  end

  // Status decoded from the registered state.
  always_comb begin
    frame_done_o = (state_q == S_DONE);
    busy_o       = (state_q == S_FILL) || (state_q == S_RUN);
  end

`ifdef NLM_LBUF_ERR_EN
  logic err_evt;

  // Short line, stray pixel outside a frame, or a malformed frame size.
  always_comb begin
    err_evt = (sof_i && (col_q != '0)) ||
              (sof_i && !sof_ok) ||
              (pix_valid_i && !sof_ok &&
               ((state_q == S_IDLE) || (state_q == S_DONE)));
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_o <= 1'b0;
    else        err_o <= err_o | err_evt;
  end
`endif

endmodule

// File: tb/tb_nlm_linebuf_ctrl.sv
// Self-checking bench for nlm_linebuf_ctrl (default parameters: 8/4/12).
module tb_nlm_linebuf_ctrl;
  localparam int AW = 8;
  localparam int NL = 4;
  localparam int HW = 12;
  localparam int BW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sof_i = 1'b0;
  logic          pix_valid_i = 1'b0;
  logic [AW:0]   img_width_i = '0;
  logic [HW-1:0] img_height_i = '0;
  logic [NL-1:0] wren_o;
  logic [AW-1:0] wraddr_o, rdaddr_o, win_col_o;
  logic          rden_o, win_valid_o, frame_done_o, busy_o;
  logic [BW-1:0] bank_ptr_o;
  logic [HW-1:0] win_row_o;
`ifdef NLM_LBUF_ERR_EN
  logic          err_o;
`endif

  nlm_linebuf_ctrl #(.ADDR_WIDTH(AW), .NUM_LINES(NL), .HGT_WIDTH(HW)) dut (
    .clk(clk), .rst_n(rst_n), .sof_i(sof_i), .pix_valid_i(pix_valid_i),
    .img_width_i(img_width_i), .img_height_i(img_height_i),
    .wren_o(wren_o), .wraddr_o(wraddr_o), .rden_o(rden_o), .rdaddr_o(rdaddr_o),
    .bank_ptr_o(bank_ptr_o), .win_valid_o(win_valid_o), .win_col_o(win_col_o),
    .win_row_o(win_row_o), .frame_done_o(frame_done_o), .busy_o(busy_o)
`ifdef NLM_LBUF_ERR_EN
    , .err_o(err_o)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic          sof, pix;
    logic [AW:0]   w;
    logic [HW-1:0] h;
    logic [NL-1:0] wren;
    logic [AW-1:0] wa;
    logic          rd, wv;
    logic [HW-1:0] row;
    logic [AW-1:0] col;
    logic [BW-1:0] bank;
    logic          done, busy;
  } vec_t;

  function automatic vec_t v(int sof, int pix, int w, int h, int wren, int wa, int rd,
                             int wv, int row, int col, int bank, int done, int busy);
    vec_t r;
    r.sof = 1'(sof); r.pix = 1'(pix); r.w = (AW+1)'(w); r.h = HW'(h);
    r.wren = NL'(wren); r.wa = AW'(wa); r.rd = 1'(rd); r.wv = 1'(wv);
    r.row = HW'(row); r.col = AW'(col); r.bank = BW'(bank);
    r.done = 1'(done); r.busy = 1'(busy);
    return r;
  endfunction

  // Full frame (or the first 'stop' pixels of one) starting with sof_i.
  task automatic run_frame(input int w, input int h, input bit gap, input int stop);
    int n = 0;
    int cyc = 0;
    bit first = 1'b1;
    while (n < stop && cyc < 4 * stop + 20) begin
      int row, col;
      bit pix;
      logic [NL-1:0] ew;
      pix = gap ? 1'($urandom_range(0, 1)) : 1'b1;
      row = n / w;
      col = n % w;
      sof_i = first; first = 1'b0;
      pix_valid_i = pix;
      img_width_i = (AW+1)'(w);
      img_height_i = HW'(h);
      ew = '0;
      if (pix) ew[row % NL] = 1'b1;
      #2;
      chk("frm_wren", 32'(wren_o), 32'(ew));
      if (pix) chk("frm_wraddr", 32'(wraddr_o), 32'(col));
      chk("frm_rden", 32'(rden_o), 32'(pix && row >= NL - 1));
      if (rden_o) chk("frm_rdaddr", 32'(rdaddr_o), 32'(col));
      @(posedge clk); #1;
      if (pix) n++;
      chk("frm_win_valid", 32'(win_valid_o), 32'(pix && row >= NL - 1));
      if (pix && row >= NL - 1) begin
        chk("frm_win_row", 32'(win_row_o), 32'(row));
        chk("frm_win_col", 32'(win_col_o), 32'(col));
      end
      chk("frm_bank_ptr", 32'(bank_ptr_o), 32'(row % NL));
      chk("frm_done", 32'(frame_done_o), 32'(pix && n == w * h));
      chk("frm_busy", 32'(busy_o), 32'(n < w * h));
      cyc++;
    end
    sof_i = 1'b0;
    pix_valid_i = 1'b0;
    if (n < stop) chk("frm_timeout", 32'(n), 32'(stop));
    if (stop == w * h) begin
      #2;
      chk("post_wren", 32'(wren_o), 32'd0);
      @(posedge clk); #1;
      chk("post_done", 32'(frame_done_o), 32'd0);
      chk("post_busy", 32'(busy_o), 32'd0);
    end
  endtask

  vec_t tbl[19];

  initial begin
    // W=2, H=5 frame with gaps, then post-frame and malformed-sof vectors.
    tbl[0]  = v(1,1,2,5,   1,0,0, 0,0,0,0, 0,1);
    tbl[1]  = v(0,1,2,5,   1,1,0, 0,0,0,0, 0,1);
    tbl[2]  = v(0,1,2,5,   2,0,0, 0,0,0,1, 0,1);
    tbl[3]  = v(0,1,2,5,   2,1,0, 0,0,0,1, 0,1);
    tbl[4]  = v(0,0,2,5,   0,0,0, 0,0,0,2, 0,1);
    tbl[5]  = v(0,1,2,5,   4,0,0, 0,0,0,2, 0,1);
    tbl[6]  = v(0,1,2,5,   4,1,0, 0,0,0,2, 0,1);
    tbl[7]  = v(0,1,2,5,   8,0,1, 1,3,0,3, 0,1);
    tbl[8]  = v(0,1,2,5,   8,1,1, 1,3,1,3, 0,1);
    tbl[9]  = v(0,0,2,5,   0,0,0, 0,0,0,0, 0,1);
    tbl[10] = v(0,1,2,5,   1,0,1, 1,4,0,0, 0,1);
    tbl[11] = v(0,1,2,5,   1,1,1, 1,4,1,0, 1,0);
    tbl[12] = v(0,1,2,5,   0,0,0, 0,0,0,1, 0,0);
    tbl[13] = v(0,1,2,5,   0,0,0, 0,0,0,1, 0,0);
    tbl[14] = v(1,1,0,5,   0,0,0, 0,0,0,1, 0,0);
    tbl[15] = v(1,1,300,5, 0,0,0, 0,0,0,1, 0,0);
    tbl[16] = v(1,1,1,0,   0,0,0, 0,0,0,1, 0,0);
    tbl[17] = v(1,1,1,1,   1,0,0, 0,0,0,0, 1,0);
    tbl[18] = v(0,0,1,1,   0,0,0, 0,0,0,1, 0,0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wren", 32'(wren_o), 32'd0);
    chk("rst_rden", 32'(rden_o), 32'd0);
    chk("rst_win_valid", 32'(win_valid_o), 32'd0);
    chk("rst_done", 32'(frame_done_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_bank", 32'(bank_ptr_o), 32'd0);
`ifdef NLM_LBUF_ERR_EN
    chk("rst_err", 32'(err_o), 32'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 19; i++) begin
      sof_i = tbl[i].sof;
      pix_valid_i = tbl[i].pix;
      img_width_i = tbl[i].w;
      img_height_i = tbl[i].h;
      #2;
      chk($sformatf("vec%0d_wren", i), 32'(wren_o), 32'(tbl[i].wren));
      if (tbl[i].wren != '0) chk($sformatf("vec%0d_wraddr", i), 32'(wraddr_o), 32'(tbl[i].wa));
      chk($sformatf("vec%0d_rden", i), 32'(rden_o), 32'(tbl[i].rd));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_win_valid", i), 32'(win_valid_o), 32'(tbl[i].wv));
      if (tbl[i].wv) begin
        chk($sformatf("vec%0d_win_row", i), 32'(win_row_o), 32'(tbl[i].row));
        chk($sformatf("vec%0d_win_col", i), 32'(win_col_o), 32'(tbl[i].col));
      end
      chk($sformatf("vec%0d_bank", i), 32'(bank_ptr_o), 32'(tbl[i].bank));
      chk($sformatf("vec%0d_done", i), 32'(frame_done_o), 32'(tbl[i].done));
      chk($sformatf("vec%0d_busy", i), 32'(busy_o), 32'(tbl[i].busy));
    end
    sof_i = 1'b0;
    pix_valid_i = 1'b0;

    run_frame(8, 6, 1'b0, 48);
    run_frame(256, 5, 1'b0, 1280);
    run_frame(8, 2, 1'b0, 16);
    run_frame(5, 6, 1'b1, 30);

    // sof_i mid-row 4, column 3
    run_frame(8, 6, 1'b0, 35);
    sof_i = 1'b1; pix_valid_i = 1'b0;
    img_width_i = 9'd8; img_height_i = 12'd6;
    #2;
    chk("mid_wren", 32'(wren_o), 32'd0);
    chk("mid_rden", 32'(rden_o), 32'd0);
    @(posedge clk); #1;
    chk("mid_busy", 32'(busy_o), 32'd1);
    chk("mid_bank", 32'(bank_ptr_o), 32'd0);
    chk("mid_win_valid", 32'(win_valid_o), 32'd0);
`ifdef NLM_LBUF_ERR_EN
    chk("mid_err", 32'(err_o), 32'd1);
`endif
    sof_i = 1'b0; pix_valid_i = 1'b1;
    #2;
    chk("mid_px_wren", 32'(wren_o), 32'd1);
    chk("mid_px_wraddr", 32'(wraddr_o), 32'd0);
    chk("mid_px_rden", 32'(rden_o), 32'd0);
    @(posedge clk); #1;
    pix_valid_i = 1'b0;
`ifdef NLM_LBUF_ERR_EN
    chk("mid_err_sticky", 32'(err_o), 32'd1);
`endif
    run_frame(8, 6, 1'b0, 48);

    // Reset pulled mid-RUN (row 3, column 6)
    run_frame(8, 6, 1'b0, 30);
    pix_valid_i = 1'b1;
    #2;
    chk("prerst_rden", 32'(rden_o), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_wren", 32'(wren_o), 32'd0);
    chk("arst_rden", 32'(rden_o), 32'd0);
    chk("arst_win_valid", 32'(win_valid_o), 32'd0);
    chk("arst_done", 32'(frame_done_o), 32'd0);
    chk("arst_busy", 32'(busy_o), 32'd0);
    chk("arst_bank", 32'(bank_ptr_o), 32'd0);
`ifdef NLM_LBUF_ERR_EN
    chk("arst_err", 32'(err_o), 32'd0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("postrst_wren", 32'(wren_o), 32'd0);
      chk("postrst_rden", 32'(rden_o), 32'd0);
      @(posedge clk); #1;
      chk("postrst_busy", 32'(busy_o), 32'd0);
      chk("postrst_win_valid", 32'(win_valid_o), 32'd0);
    end
    pix_valid_i = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
